// File: rtl/clock_divider_multi_pkg.sv
// Shared types and constants for the multi-channel divider.
// Default widths, config word layout, control/output bundles.
package clock_divider_multi_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_ADD_W  = 16;
  localparam int DEF_SUB_W  = 15;
  localparam int DEF_CNT_W  = 16;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CH_W  = ch_w(DEF_NUM_CH);
  localparam int DEF_CFG_W = DEF_ADD_W + DEF_SUB_W + 1;

  typedef struct packed {
    logic                 fractional_mode;
    logic [DEF_SUB_W-1:0] subtractor;
    logic [DEF_ADD_W-1:0] adder;
  } cfg_t;

  typedef struct packed {
    logic [DEF_CH_W-1:0]   select;
    logic                  write_config;
    logic                  write_count;
    cfg_t                  write_data;
    logic [DEF_NUM_CH-1:0] start_mask;
    logic [DEF_NUM_CH-1:0] stop_mask;
    logic [DEF_NUM_CH-1:0] disable_fractional;
  } ctrl_t;

  typedef struct packed {
    cfg_t                  config_data;
    logic [DEF_NUM_CH-1:0] running;
    logic [DEF_NUM_CH-1:0] clock_enable;
    logic [DEF_NUM_CH-1:0] done;
  } out_t;

endpackage

// File: rtl/clock_divider_multi_channel.sv
// One divider channel: config, burst count, accumulator,
// running flag and registered enable/done pulses.
module clock_divider_channel
  import clock_divider_multi_pkg::*;
#(
  parameter int ADD_WIDTH = DEF_ADD_W,
  parameter int SUB_WIDTH = DEF_SUB_W,
  parameter int CNT_WIDTH = DEF_CNT_W,
  localparam int CFG_W = ADD_WIDTH + SUB_WIDTH + 1,
  localparam int ACC_W = ADD_WIDTH + SUB_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             wr_cfg,
  input  logic             wr_cnt,
  input  logic [CFG_W-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  input  logic             dis_frac,
  output logic [CFG_W-1:0] cfg_out,
  output logic             running,
  output logic             clock_enable,
  output logic             done
);

  logic                 mode_q;
  logic [SUB_WIDTH-1:0] sub_q;
  logic [ADD_WIDTH-1:0] add_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 run_d, en_d, done_d, fire;
  logic [ACC_W-1:0]     n_val;
  logic [ADD_WIDTH-1:0] facc;

  assign n_val   = {sub_q, add_q};
  assign facc    = acc_q[ADD_WIDTH-1:0];
  assign cfg_out = {mode_q, sub_q, add_q};

  // Config and count registers; disable_fractional beats a mode write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      sub_q  <= '0;
      add_q  <= '0;
      cnt_q  <= '0;
    end else if (clk_en) begin
      if (wr_cfg) begin
        mode_q <= wr_data[CFG_W-1];
        sub_q  <= wr_data[ACC_W-1:ADD_WIDTH];
        add_q  <= wr_data[ADD_WIDTH-1:0];
      end
      if (dis_frac)
        mode_q <= 1'b0;
      if (wr_cnt)
        cnt_q <= wr_data[CNT_WIDTH-1:0];
    end
  end

  // Next-state: start beats stop; accumulator step and burst accounting
  always_comb begin
    acc_d  = acc_q;
    rem_d  = rem_q;
    run_d  = running;
    en_d   = 1'b0;
    done_d = 1'b0;
    fire   = 1'b0;
    if (start) begin
      acc_d = mode_q ? ACC_W'(add_q >> 1) : n_val;
      rem_d = cnt_q;
      run_d = 1'b1;
    end else if (stop) begin
      run_d = 1'b0;
    end else if (running) begin
      if (mode_q) begin
        if (facc[ADD_WIDTH-1]) begin
          acc_d = ACC_W'(facc + add_q);
          fire  = 1'b1;
        end else begin
          acc_d = ACC_W'(facc - ADD_WIDTH'(sub_q));
        end
      end else if (acc_q == '0) begin
        acc_d = n_val;
        fire  = 1'b1;
      end else begin
        acc_d = acc_q - 1'b1;
      end
      if (fire) begin
        en_d = 1'b1;
        if (rem_q == CNT_WIDTH'(1)) begin
          rem_d  = '0;
          run_d  = 1'b0;
          done_d = 1'b1;
        end else if (rem_q != '0) begin
          rem_d = rem_q - 1'b1;
        end
      end
    end
  end

  // Run-state registers, held while clk_en is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= '0;
      rem_q        <= '0;
      running      <= 1'b0;
      clock_enable <= 1'b0;
      done         <= 1'b0;
    end else if (clk_en) begin
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      running      <= run_d;
      clock_enable <= en_d;
      done         <= done_d;
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent dividers behind one control port;
// select decode and config readback live here.
module clock_divider_multi
  import clock_divider_multi_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int ADD_WIDTH = DEF_ADD_W,
  parameter int SUB_WIDTH = DEF_SUB_W,
  parameter int CNT_WIDTH = DEF_CNT_W,
  localparam int CH_W  = ch_w(NUM_CH),
  localparam int CFG_W = ADD_WIDTH + SUB_WIDTH + 1
) (
  input  logic              clk,
  input  logic              clk__enable,
  input  logic              reset_n,
  input  logic [CH_W-1:0]   divider_control__select,
  input  logic              divider_control__write_config,
  input  logic              divider_control__write_count,
  input  logic [CFG_W-1:0]  divider_control__write_data,
  input  logic [NUM_CH-1:0] divider_control__start_mask,
  input  logic [NUM_CH-1:0] divider_control__stop_mask,
  input  logic [NUM_CH-1:0] divider_control__disable_fractional,
  output logic [CFG_W-1:0]  divider_output__config_data,
  output logic [NUM_CH-1:0] divider_output__running,
  output logic [NUM_CH-1:0] divider_output__clock_enable,
  output logic [NUM_CH-1:0] divider_output__done
);

  logic [CFG_W-1:0] cfg_arr [NUM_CH];
  logic [NUM_CH-1:0] hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hit[i] = (divider_control__select == CH_W'(i));

    clock_divider_channel #(
      .ADD_WIDTH (ADD_WIDTH),
      .SUB_WIDTH (SUB_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .clk_en       (clk__enable),
      .wr_cfg       (divider_control__write_config & hit[i]),
      .wr_cnt       (divider_control__write_count & hit[i]),
      .wr_data      (divider_control__write_data),
      .start        (divider_control__start_mask[i]),
      .stop         (divider_control__stop_mask[i]),
      .dis_frac     (divider_control__disable_fractional[i]),
      .cfg_out      (cfg_arr[i]),
      .running      (divider_output__running[i]),
      .clock_enable (divider_output__clock_enable[i]),
      .done         (divider_output__done[i])
    );
  end

  // Readback mux; an unmatched select reads as zero
  always_comb begin
    divider_output__config_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (hit[i])
        divider_output__config_data = cfg_arr[i];
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: expected pulse
// offsets are queued at start and popped as pulses appear.
module tb_clock_divider_multi;
  import clock_divider_multi_pkg::*;

  logic        clk = 1'b0;
  logic        clk_en;
  logic        reset_n;
  logic [1:0]  sel;
  logic        wcfg, wcnt;
  logic [31:0] wdata;
  logic [3:0]  start_m, stop_m, dis_m;
  logic [31:0] cfg_rd;
  logic [3:0]  run, en, dn;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int d_at, d_n;
  cfg_t c;

  always #5 clk = ~clk;

  clock_divider_multi dut (
    .clk                                 (clk),
    .clk__enable                         (clk_en),
    .reset_n                             (reset_n),
    .divider_control__select             (sel),
    .divider_control__write_config       (wcfg),
    .divider_control__write_count        (wcnt),
    .divider_control__write_data         (wdata),
    .divider_control__start_mask         (start_m),
    .divider_control__stop_mask          (stop_m),
    .divider_control__disable_fractional (dis_m),
    .divider_output__config_data         (cfg_rd),
    .divider_output__running             (run),
    .divider_output__clock_enable        (en),
    .divider_output__done                (dn)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cfg(input logic [1:0] s, input logic [31:0] d);
    sel = s; wdata = d; wcfg = 1'b1;
    tick;
    wcfg = 1'b0;
  endtask

  task automatic wr_cnt(input logic [1:0] s, input logic [31:0] d);
    sel = s; wdata = d; wcnt = 1'b1;
    tick;
    wcnt = 1'b0;
  endtask

  task automatic go(input logic [3:0] m);
    start_m = m;
    tick;
    start_m = 4'h0;
    check("start edge quiet", en & m, 0);
  endtask

  task automatic halt(input logic [3:0] m);
    stop_m = m;
    tick;
    stop_m = 4'h0;
  endtask

  task automatic watch(input string tag, input int ch, input int n,
                       output int done_at, output int done_n);
    done_at = 0;
    done_n  = 0;
    for (int k = 1; k <= n; k++) begin
      tick;
      if (en[ch]) begin
        if (exp_q.size() == 0) check({tag, " extra"}, k, 0);
        else check(tag, k, exp_q.pop_front());
      end
      if (dn[ch]) begin
        done_at = k;
        done_n++;
      end
    end
    check({tag, " left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    clk_en = 1'b1; reset_n = 1'b0;
    sel = '0; wcfg = 1'b0; wcnt = 1'b0; wdata = '0;
    start_m = '0; stop_m = '0; dis_m = '0;
    repeat (2) tick;
    reset_n = 1'b1;
    tick;
    check("rst run", run, 0);
    check("rst en", en, 0);
    check("rst done", dn, 0);
    check("rst cfg", cfg_rd, 0);

    wr_cfg(0, 32'h0000_0003);
    check("cfg rd", cfg_rd, 32'h3);
    go(4'b0001);
    for (int i = 1; i <= 4; i++) exp_q.push_back(4 * i);
    watch("int n3", 0, 17, d_at, d_n);

    wr_cfg(0, 32'h0);
    go(4'b0001);
    for (int i = 1; i <= 6; i++) exp_q.push_back(i);
    watch("int n0", 0, 6, d_at, d_n);
    halt(4'hF);

    c = '{fractional_mode: 1'b1, subtractor: 15'd1, adder: 16'd3};
    wr_cfg(1, c);
    go(4'b0010);
    for (int i = 0; i < 4; i++) exp_q.push_back(3 + 4 * i);
    watch("frac", 1, 17, d_at, d_n);
    halt(4'hF);

    wr_cfg(2, 32'h1);
    wr_cnt(2, 32'd3);
    go(4'b0100);
    for (int i = 1; i <= 3; i++) exp_q.push_back(2 * i);
    watch("burst", 2, 14, d_at, d_n);
    check("burst done at", d_at, 6);
    check("burst done n", d_n, 1);
    check("burst run", run[2], 0);

    wr_cfg(0, 32'h2);
    wr_cfg(3, 32'h2);
    go(4'b1001);
    for (int k = 1; k <= 12; k++) begin
      tick;
      check("sync", en & 4'b1001, (k % 3 == 0) ? 4'b1001 : 4'b0000);
    end
    halt(4'b0001);
    check("stop ch0", run, 4'b1000);
    for (int k = 14; k <= 19; k++) begin
      tick;
      check("after stop", en & 4'b1001, (k % 3 == 0) ? 4'b1000 : 4'b0000);
    end
    halt(4'hF);

    start_m = 4'b0010; stop_m = 4'b0010;
    tick;
    start_m = '0; stop_m = '0;
    check("start wins", run, 4'b0010);
    halt(4'hF);

    c = '{fractional_mode: 1'b1, subtractor: 15'd5, adder: 16'd9};
    dis_m = 4'b0010;
    wr_cfg(1, c);
    dis_m = '0;
    check("dis frac mode", cfg_rd[31], 0);
    check("dis frac data", cfg_rd[30:0], 32'h0005_0009);

    wr_cfg(0, 32'h2);
    go(4'b0001);
    repeat (3) tick;
    check("pre freeze en", en, 4'b0001);
    clk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("freeze en", en, 4'b0001);
      check("freeze run", run, 4'b0001);
    end
    clk_en = 1'b1;
    tick;
    check("thaw 1", en, 0);
    tick;
    check("thaw 2", en, 0);
    tick;
    check("thaw 3", en, 4'b0001);
    halt(4'hF);

    wr_cfg(2, 32'h1);
    go(4'b0100);
    tick;
    tick;
    check("mid burst pulse", en[2], 1);
    #2 reset_n = 1'b0;
    #1;
    check("async run", run, 0);
    check("async en", en, 0);
    check("async done", dn, 0);
    check("async cfg", cfg_rd, 0);
    repeat (2) tick;
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      check("post rst done", dn, 0);
      check("post rst run", run, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
